nios_system_sysid_checker: RTL

- Boot-time controller that sequences reads of the system-ID slave (word 0 = ID, word 1 = build timestamp) and compares both words against build-time expected values.
- Retries on mismatch, then latches a pass/fail verdict.
- Sits between the sysid slave's address/readdata pins and board status logic (LED / HEX fail indicator, hold-off of the Nios reset release).
- Re-runnable by a start pulse.

---
 rtl/nios_system_sysid_pkg.sv | 22 ++
 rtl/nios_system_sysid_checker.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/nios_system_sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
// Word 0 of the sysid slave is the ID and word 1 is the build timestamp.
package nios_system_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_RD_TS,
    ST_CHECK,
    ST_DONE
  } sysid_chk_state_t;

  localparam logic SID_ADDR_ID = 1'b0;
  localparam logic SID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1459559916;

  localparam int CNT_W   = 4;
  localparam int RETRY_W = 3;

endpackage

// File: rtl/nios_system_sysid_checker.sv
// Boot-time sysid checker: reads ID and timestamp words, compares them with the
// build-time values, retries on mismatch and latches a pass/fail verdict.
module nios_system_sysid_checker
  import nios_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID   = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS   = DEFAULT_EXPECTED_TS,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter bit          AUTO_START    = 1'b1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  output logic         sid_address,
  input  logic [31:0]  sid_readdata,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         fail,
  output logic         id_ok,
  output logic         ts_ok,
  output logic [31:0]  id_value,
  output logic [31:0]  ts_value,
  output logic [2:0]   retry_count
);

  localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  sysid_chk_state_t     state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 auto_q, auto_d;
  logic                 addr_q, addr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;
  logic                 id_ok_q, id_ok_d;
  logic                 ts_ok_q, ts_ok_d;
  logic [31:0]          id_val_q, id_val_d;
  logic [31:0]          ts_val_q, ts_val_d;
  logic                 id_eq, ts_eq;

  assign id_eq = (id_val_q == EXPECTED_ID);
  assign ts_eq = (ts_val_q == EXPECTED_TS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      retry_q  <= '0;
      auto_q   <= AUTO_START;
      addr_q   <= SID_ADDR_ID;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      id_val_q <= '0;
      ts_val_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      auto_q   <= auto_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      id_ok_q  <= id_ok_d;
      ts_ok_q  <= ts_ok_d;
      id_val_q <= id_val_d;
      ts_val_q <= ts_val_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    auto_d   = auto_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    id_ok_d  = id_ok_q;
    ts_ok_d  = ts_ok_q;
    id_val_d = id_val_q;
    ts_val_d = ts_val_q;
    case (state_q)
      // The auto-start flag is one-shot; it is already clear by the time DONE is reached.
      ST_IDLE, ST_DONE: begin
        if (start || auto_q) begin
          state_d = ST_RD_ID;
          cnt_d   = SETTLE_LD;
          retry_d = '0;
          auto_d  = 1'b0;
          addr_d  = SID_ADDR_ID;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
        end
      end
      ST_RD_ID: begin
        if (cnt_q == '0) begin
          id_val_d = sid_readdata;
          cnt_d    = SETTLE_LD;
          addr_d   = SID_ADDR_TS;
          state_d  = ST_RD_TS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RD_TS: begin
        if (cnt_q == '0) begin
          ts_val_d = sid_readdata;
          state_d  = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CHECK: begin
        id_ok_d = id_eq;
        ts_ok_d = ts_eq;
        if (id_eq && ts_eq) begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          cnt_d   = SETTLE_LD;
          addr_d  = SID_ADDR_ID;
          state_d = ST_RD_ID;
        end else begin
          state_d = ST_DONE;
          fail_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sid_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign id_value    = id_val_q;
  assign ts_value    = ts_val_q;
  assign retry_count = retry_q;

endmodule
